oled_spi_rx: RTL and testbench

Receive-side model of the Pmod OLEDrgb (SSD1331) SPI link: deserializes the write-only stream driven by `spi_master` (SCK/MOSI/DC/CS), frames bytes, and parses SSD1331 command sequences into decoded events. It sits in the OLED IP as a loopback checker/monitor alongside `init_controller` and `bar_graph_controller`. Its decoded rectangle output lets hardware and benches confirm bar-graph draws without a physical panel.

---
 rtl/oled_spi_rx.sv | 198 +++++++++++++++++++
 tb/tb_oled_spi_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_rx.sv
// Receive-side monitor for the SSD1331 SPI link: synchronizes SCK/MOSI/DC/CS,
// frames bytes MSB-first and decodes command sequences, rectangles and pixel counts.
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sclk_i,
    input  logic        mosi_i,
    input  logic        cs_n_i,
    input  logic        dc_i,
    output logic        byte_valid_o,
    output logic [7:0]  byte_o,
    output logic        byte_dc_o,
    output logic        cmd_valid_o,
    output logic [7:0]  cmd_op_o,
    output logic        rect_valid_o,
    output logic [7:0]  rect_x0_o,
    output logic [7:0]  rect_y0_o,
    output logic [7:0]  rect_x1_o,
    output logic [7:0]  rect_y1_o,
    output logic [23:0] rect_line_o,
    output logic [23:0] rect_fill_o,
    output logic [15:0] pix_cnt_o,
    output logic        err_o
);

    typedef enum logic {IDLE, PARAM} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sclk_prev;
    logic                   rise_q;
    logic                   mosi_q;
    logic                   dc_q;
    logic                   cs_q;

    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   cs_err;

    state_t                 state;
    logic [7:0]             opcode;
    logic [3:0]             total;
    logic [3:0]             remaining;
    logic [3:0]             param_idx;
    logic [7:0]             params [10];
    logic                   parse_err;

    function automatic logic [3:0] param_count(input logic [7:0] op);
        case (op)
            8'h22:                      param_count = 4'd10;
            8'h21:                      param_count = 4'd7;
            8'h25:                      param_count = 4'd4;
            8'h15, 8'h75:               param_count = 4'd2;
            8'h26, 8'h81, 8'h82, 8'h83,
            8'h87, 8'h8A, 8'h8B, 8'h8C,
            8'hA0, 8'hA1, 8'hA2, 8'hA8,
            8'hAD, 8'hB0, 8'hB1, 8'hB3,
            8'hBB, 8'hBE:               param_count = 4'd1;
            default:                    param_count = 4'd0;
        endcase
    endfunction

    assign param_idx = total - remaining;
    assign err_o     = cs_err | parse_err;

    // Synchronizers, then one extra stage so MOSI/DC/CS line up with the detected SCLK rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b0;
            rise_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc_i};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            rise_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            mosi_q    <= mosi_sync[SYNC_STAGES-1];
            dc_q      <= dc_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    // Byte framer: deselect drops any partial byte and flags it if bits were pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            byte_o       <= '0;
            byte_dc_o    <= 1'b0;
            byte_valid_o <= 1'b0;
            cs_err       <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            cs_err       <= 1'b0;
            if (cs_q) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                if (bit_cnt != 3'd0) begin
                    cs_err <= 1'b1;
                end
            end else if (rise_q) begin
                shift_reg <= {shift_reg[6:0], mosi_q};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_o       <= {shift_reg[6:0], mosi_q};
                    byte_dc_o    <= dc_q;
                    byte_valid_o <= 1'b1;
                end
            end
        end
    end

    // Command parser: opcode, then table-driven parameter count; the last
    // rectangle parameter is taken straight from the byte being completed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            opcode       <= '0;
            total        <= '0;
            remaining    <= '0;
            for (int i = 0; i < 10; i++) begin
                params[i] <= '0;
            end
            parse_err    <= 1'b0;
            cmd_valid_o  <= 1'b0;
            cmd_op_o     <= '0;
            rect_valid_o <= 1'b0;
            rect_x0_o    <= '0;
            rect_y0_o    <= '0;
            rect_x1_o    <= '0;
            rect_y1_o    <= '0;
            rect_line_o  <= '0;
            rect_fill_o  <= '0;
            pix_cnt_o    <= '0;
        end else begin
            cmd_valid_o  <= 1'b0;
            rect_valid_o <= 1'b0;
            parse_err    <= 1'b0;
            if (byte_valid_o) begin
                case (state)
                    IDLE: begin
                        if (byte_dc_o) begin
                            pix_cnt_o <= pix_cnt_o + 16'd1;
                        end else begin
                            opcode    <= byte_o;
                            total     <= param_count(byte_o);
                            remaining <= param_count(byte_o);
                            if (param_count(byte_o) == 4'd0) begin
                                cmd_valid_o <= 1'b1;
                                cmd_op_o    <= byte_o;
                            end else begin
                                state <= PARAM;
                            end
                        end
                    end
                    PARAM: begin
                        if (byte_dc_o) begin
                            parse_err <= 1'b1;
                            pix_cnt_o <= pix_cnt_o + 16'd1;
                            state     <= IDLE;
                        end else begin
                            params[param_idx] <= byte_o;
                            remaining         <= remaining - 4'd1;
                            if (remaining == 4'd1) begin
                                cmd_valid_o <= 1'b1;
                                cmd_op_o    <= opcode;
                                state       <= IDLE;
                                if (opcode == 8'h22) begin
                                    rect_valid_o <= 1'b1;
                                    rect_x0_o    <= params[0];
                                    rect_y0_o    <= params[1];
                                    rect_x1_o    <= params[2];
                                    rect_y1_o    <= params[3];
                                    rect_line_o  <= {params[4], params[5], params[6]};
                                    rect_fill_o  <= {params[7], params[8], byte_o};
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: table vectors, hand sequences for
// error/reset corners, and a randomized command stream against a queue-based model.
module tb_oled_spi_rx;

    localparam int HALF = 4;
    localparam int LAT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        dc;
    logic        byte_valid_o;
    logic [7:0]  byte_o;
    logic        byte_dc_o;
    logic        cmd_valid_o;
    logic [7:0]  cmd_op_o;
    logic        rect_valid_o;
    logic [7:0]  rect_x0_o;
    logic [7:0]  rect_y0_o;
    logic [7:0]  rect_x1_o;
    logic [7:0]  rect_y1_o;
    logic [23:0] rect_line_o;
    logic [23:0] rect_fill_o;
    logic [15:0] pix_cnt_o;
    logic        err_o;

    typedef struct packed {
        logic [7:0]  x0;
        logic [7:0]  y0;
        logic [7:0]  x1;
        logic [7:0]  y1;
        logic [23:0] line;
        logic [23:0] fill;
    } rect_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       exp_cmd;
        logic [7:0] exp_op;
    } vec_t;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [8:0] got_bytes[$];
    logic [7:0] got_cmds[$];
    rect_t      got_rects[$];
    int         got_errs    = 0;
    int         rect_no_cmd = 0;

    logic [8:0] exp_bytes[$];
    logic [7:0] exp_cmds[$];
    rect_t      exp_rects[$];
    int         exp_errs = 0;
    logic [15:0] exp_pix = '0;
    logic [7:0] pend[$];

    always #5 clk = ~clk;

    oled_spi_rx #(.SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sclk_i       (sclk),
        .mosi_i       (mosi),
        .cs_n_i       (cs_n),
        .dc_i         (dc),
        .byte_valid_o (byte_valid_o),
        .byte_o       (byte_o),
        .byte_dc_o    (byte_dc_o),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_op_o     (cmd_op_o),
        .rect_valid_o (rect_valid_o),
        .rect_x0_o    (rect_x0_o),
        .rect_y0_o    (rect_y0_o),
        .rect_x1_o    (rect_x1_o),
        .rect_y1_o    (rect_y1_o),
        .rect_line_o  (rect_line_o),
        .rect_fill_o  (rect_fill_o),
        .pix_cnt_o    (pix_cnt_o),
        .err_o        (err_o)
    );

    // Event monitor, sampled on the falling edge away from DUT updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid_o) got_bytes.push_back({byte_dc_o, byte_o});
            if (cmd_valid_o)  got_cmds.push_back(cmd_op_o);
            if (rect_valid_o) begin
                got_rects.push_back({rect_x0_o, rect_y0_o, rect_x1_o, rect_y1_o,
                                     rect_line_o, rect_fill_o});
                if (!cmd_valid_o) rect_no_cmd++;
            end
            if (err_o) got_errs++;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic int ref_params(input logic [7:0] op);
        if (op == 8'h22) return 10;
        if (op == 8'h21) return 7;
        if (op == 8'h25) return 4;
        if (op == 8'h15 || op == 8'h75) return 2;
        if (op inside {8'h26, 8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0,
                       8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE})
            return 1;
        return 0;
    endfunction

    // Reference model: gather a command's bytes in a list until it is as long as the table says.
    task automatic model_byte(input logic [7:0] b, input logic d);
        exp_bytes.push_back({d, b});
        if (d) begin
            if (pend.size() > 0) begin
                exp_errs++;
                pend.delete();
            end
            exp_pix++;
        end else begin
            pend.push_back(b);
            if (pend.size() == 1 + ref_params(pend[0])) begin
                exp_cmds.push_back(pend[0]);
                if (pend[0] == 8'h22)
                    exp_rects.push_back({pend[1], pend[2], pend[3], pend[4], pend[5],
                                         pend[6], pend[7], pend[8], pend[9], pend[10]});
                pend.delete();
            end
        end
    endtask

    task automatic clear_all();
        got_bytes.delete(); got_cmds.delete(); got_rects.delete();
        exp_bytes.delete(); exp_cmds.delete(); exp_rects.delete();
        got_errs = 0;
        exp_errs = 0;
    endtask

    task automatic drive_bits(input logic [7:0] b, input logic d, input int n,
                              input bit check_lat);
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            dc   = d;
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk);
                #1;
                if (check_lat && i == 7 && k == LAT - 1)
                    check_output("latency_early", {31'b0, byte_valid_o}, 32'd0);
                if (check_lat && i == 7 && k == LAT)
                    check_output("latency_exact", {31'b0, byte_valid_o}, 32'd1);
            end
            @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        drive_bits(b, d, 8, 1'b0);
        model_byte(b, d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_byte_valid"}, {31'b0, byte_valid_o}, 32'd0);
        check_output({tag, "_byte"}, {23'b0, byte_dc_o, byte_o}, 32'd0);
        check_output({tag, "_cmd"}, {23'b0, cmd_valid_o, cmd_op_o}, 32'd0);
        check_output({tag, "_rect_valid"}, {31'b0, rect_valid_o}, 32'd0);
        check_output({tag, "_rect_xy"}, {rect_x0_o, rect_y0_o, rect_x1_o, rect_y1_o}, 32'd0);
        check_output({tag, "_rect_col"}, {8'b0, rect_line_o | rect_fill_o}, 32'd0);
        check_output({tag, "_pix"}, {16'b0, pix_cnt_o}, 32'd0);
        check_output({tag, "_err"}, {31'b0, err_o}, 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs(tag);
        rst = 1'b0;
        pend.delete();
        exp_pix = '0;
        clear_all();
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        repeat (12) @(negedge clk);
        check_output({tag, "_byte_count"}, got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
            check_output({tag, "_byte"}, {23'b0, got_bytes[i]}, {23'b0, exp_bytes[i]});
        check_output({tag, "_cmd_count"}, got_cmds.size(), exp_cmds.size());
        for (int i = 0; i < got_cmds.size() && i < exp_cmds.size(); i++)
            check_output({tag, "_cmd_op"}, {24'b0, got_cmds[i]}, {24'b0, exp_cmds[i]});
        check_output({tag, "_rect_count"}, got_rects.size(), exp_rects.size());
        for (int i = 0; i < got_rects.size() && i < exp_rects.size(); i++) begin
            check_output({tag, "_rect_xy"},
                         {got_rects[i].x0, got_rects[i].y0, got_rects[i].x1, got_rects[i].y1},
                         {exp_rects[i].x0, exp_rects[i].y0, exp_rects[i].x1, exp_rects[i].y1});
            check_output({tag, "_rect_line"}, {8'b0, got_rects[i].line}, {8'b0, exp_rects[i].line});
            check_output({tag, "_rect_fill"}, {8'b0, got_rects[i].fill}, {8'b0, exp_rects[i].fill});
        end
        check_output({tag, "_err_count"}, got_errs, exp_errs);
        check_output({tag, "_pix"}, {16'b0, pix_cnt_o}, {16'b0, exp_pix});
        clear_all();
    endtask

    vec_t       vecs[8];
    logic [7:0] pool[10];
    logic [7:0] init_seq[38];
    logic [7:0] rect_seq[11];
    logic [7:0] rb;
    logic [7:0] op;

    initial begin
        vecs[0] = '{8'hAE, 1'b0, 1'b1, 8'hAE};
        vecs[1] = '{8'hAF, 1'b0, 1'b1, 8'hAF};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{8'hA4, 1'b0, 1'b1, 8'hA4};
        vecs[4] = '{8'hE3, 1'b0, 1'b1, 8'hE3};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{8'h2E, 1'b0, 1'b1, 8'h2E};
        pool = '{8'h22, 8'h15, 8'h75, 8'h81, 8'hA0, 8'hAE, 8'hAF, 8'hA4, 8'h21, 8'h25};
        init_seq = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8, 8'h3F,
                     8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0, 8'h8A, 8'h64,
                     8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE, 8'h3E, 8'h87, 8'h06,
                     8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D, 8'h2E, 8'hAF};
        rect_seq = '{8'h22, 8'h00, 8'h20, 8'h05, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};

        rst  = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        dc   = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        clear_all();

        // Single zero-parameter command with the byte latency measured.
        drive_bits(8'hAE, 1'b0, 8, 1'b1);
        model_byte(8'hAE, 1'b0);
        compare_all("ae");

        // Table-driven single bytes.
        for (int v = 0; v < 8; v++) begin
            send_byte(vecs[v].data, vecs[v].dc);
            repeat (12) @(negedge clk);
            check_output("vec_byte_count", got_bytes.size(), 1);
            if (got_bytes.size() > 0)
                check_output("vec_byte", {23'b0, got_bytes[0]}, {23'b0, vecs[v].dc, vecs[v].data});
            check_output("vec_cmd_present", got_cmds.size(), {31'b0, vecs[v].exp_cmd});
            if (got_cmds.size() > 0)
                check_output("vec_cmd_op", {24'b0, got_cmds[0]}, {24'b0, vecs[v].exp_op});
            clear_all();
        end
        check_output("vec_pix", {16'b0, pix_cnt_o}, {16'b0, exp_pix});

        // Draw-rectangle.
        for (int i = 0; i < 11; i++) send_byte(rect_seq[i], 1'b0);
        compare_all("rect");
        check_output("rect_xy_abs", {rect_x0_o, rect_y0_o, rect_x1_o, rect_y1_o}, 32'h0020053F);
        check_output("rect_line_abs", {8'b0, rect_line_o}, 32'h00FF0000);
        check_output("rect_fill_abs", {8'b0, rect_fill_o}, 32'h0000FF00);
        check_output("rect_with_cmd", rect_no_cmd, 0);

        // Pixel byte interrupting a parameter list.
        apply_reset("rst_a");
        send_byte(8'h15, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h55, 1'b1);
        repeat (12) @(negedge clk);
        check_output("abort_err", got_errs, 1);
        check_output("abort_no_cmd", got_cmds.size(), 0);
        check_output("abort_pix", {16'b0, pix_cnt_o}, 32'd1);
        send_byte(8'hAF, 1'b0);
        compare_all("after_abort");

        // Partial byte cut short by deselect.
        drive_bits(8'hB8, 1'b0, 5, 1'b0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("cs_abort_err", got_errs, 1);
        got_errs = 0;
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(8'hA5, 1'b0);
        compare_all("after_cs");

        // Reset in the middle of a rectangle command.
        for (int i = 0; i < 4; i++) send_byte(rect_seq[i], 1'b0);
        repeat (8) @(negedge clk);
        apply_reset("rst_b");
        send_byte(8'hAF, 1'b0);
        compare_all("after_rst");
        check_output("after_rst_op", {24'b0, cmd_op_o}, 32'h000000AF);

        // Randomized command stream.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                rb = 8'($urandom_range(0, 255));
                send_byte(rb, 1'b1);
            end else begin
                op = pool[$urandom_range(0, 9)];
                send_byte(op, 1'b0);
                for (int j = 0; j < ref_params(op); j++) begin
                    rb = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 19) == 0) begin
                        send_byte(rb, 1'b1);
                        break;
                    end
                    send_byte(rb, 1'b0);
                end
            end
        end
        compare_all("random");

        // Panel init sequence followed by a bar draw at y=32.
        for (int i = 0; i < 38; i++) send_byte(init_seq[i], 1'b0);
        repeat (12) @(negedge clk);
        check_output("init_cmd_count", got_cmds.size(), 21);
        compare_all("init");
        send_byte(8'h25, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h5F, 1'b0);
        send_byte(8'h3F, 1'b0);
        rect_seq = '{8'h22, 8'h10, 8'h20, 8'h18, 8'h3F, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h00};
        for (int i = 0; i < 11; i++) send_byte(rect_seq[i], 1'b0);
        repeat (12) @(negedge clk);
        check_output("bar_rect_count", got_rects.size(), 1);
        if (got_rects.size() > 0)
            check_output("bar_y0", {24'b0, got_rects[0].y0}, 32'd32);
        compare_all("bar");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
